// File: rtl/tlc_pkg.sv
`default_nettype none
// ============================================================================
// Module : tlc_pkg
// Brief  : Shared phase encoding, lamp constants and counter sizing for
//          the N-way traffic-light controller.
// Rev    : 1.0  initial release
// ============================================================================
package tlc_pkg;

    typedef enum logic [1:0] {
        PH_GREEN   = 2'd0,
        PH_YELLOW  = 2'd1,
        PH_ALL_RED = 2'd2,
        PH_WALK    = 2'd3
    } phase_e;

    // Lamp triple packed as {green, yellow, red}
    localparam logic [2:0] LAMP_GREEN  = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_RED    = 3'b001;

    function automatic int cnt_width(input int a, input int b, input int c,
                                     input int d, input int e);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (e > m) m = e;
        if (m < 1) return 1;
        return $clog2(m + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tlc_if.sv
`default_nettype none
// ============================================================================
// Module : tlc_if
// Brief  : Sensor and lamp bundle of the traffic-light controller.
//          Pedestrian signals exist only when TLC_PED_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
interface tlc_if #(
    parameter int N_WAYS = 3
) ();
    localparam int AW = $clog2(N_WAYS);

    logic [N_WAYS-1:0] car_sense;
    logic [N_WAYS-1:0] green;
    logic [N_WAYS-1:0] yellow;
    logic [N_WAYS-1:0] red;
    logic [AW-1:0]     active_way;
    logic [1:0]        phase;
`ifdef TLC_PED_EN
    logic              ped_req;
    logic              walk;

    modport master (input car_sense, ped_req,
                    output green, yellow, red, active_way, phase, walk);
    modport slave  (output car_sense, ped_req,
                    input green, yellow, red, active_way, phase, walk);
`else
    modport master (input car_sense,
                    output green, yellow, red, active_way, phase);
    modport slave  (output car_sense,
                    input green, yellow, red, active_way, phase);
`endif
endinterface
`default_nettype wire

// File: rtl/tlc_phase_timer.sv
`default_nettype none
// ============================================================================
// Module : tlc_phase_timer
// Brief  : Loadable saturating down-counter; done while the count is zero.
// Rev    : 1.0  initial release
// ============================================================================
module tlc_phase_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             done
);
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load)
            count_d = load_val;
        else if (count_q != '0)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end

    assign done = (count_q == '0);
endmodule
`default_nettype wire

// File: rtl/traffic_light_ctrl.sv
`default_nettype none
// ============================================================================
// Module : traffic_light_ctrl
// Brief  : N-way round-robin traffic-light controller with min/max green.
//          Define TLC_PED_EN to add the pedestrian WALK phase.
// Rev    : 1.0  initial release
// ============================================================================
module traffic_light_ctrl
    import tlc_pkg::*;
#(
    parameter int N_WAYS        = 3,
    parameter int MIN_GREEN     = 4,
    parameter int MAX_GREEN     = 10,
    parameter int YELLOW_CYCLES = 2,
    parameter int ALLRED_CYCLES = 1,
    parameter int WALK_CYCLES   = 5
) (
    input  logic  clk,
    input  logic  rst_n,
    tlc_if.master bus
);
    localparam int AW = $clog2(N_WAYS);
    localparam int CW = cnt_width(MIN_GREEN, MAX_GREEN, YELLOW_CYCLES,
                                  ALLRED_CYCLES, WALK_CYCLES);

    localparam logic [CW:0]   C_MIN_X = (CW+1)'(MIN_GREEN);
    localparam logic [CW:0]   C_MAX_X = (CW+1)'(MAX_GREEN);
    localparam logic [CW-1:0] C_MAX   = CW'(MAX_GREEN);
    localparam logic [CW-1:0] C_YEL   = CW'(YELLOW_CYCLES - 1);
    localparam logic [CW-1:0] C_AR    = CW'(ALLRED_CYCLES - 1);
    localparam logic [N_WAYS-1:0] C_LAMP0 = N_WAYS'(1);

    phase_e            phase_q, phase_d;
    logic [AW-1:0]     way_q, way_d;
    logic [CW-1:0]     g_q, g_d;
    logic [N_WAYS-1:0] req_q, req_d;
    logic [N_WAYS-1:0] green_q, green_d, yellow_q, yellow_d, red_q, red_d;
    logic [N_WAYS-1:0] way_oh;
    logic [CW:0]       g_inc;
    logic [2:0]        lamp;
    logic              pending, enter_green, tmr_load, tmr_done;
    logic [CW-1:0]     tmr_val;
`ifdef TLC_PED_EN
    localparam logic [CW-1:0] C_WALK = CW'(WALK_CYCLES - 1);
    logic              ped_q, ped_d, walk_q, walk_d;
`endif

    // First requesting approach after cur, wrapping; cur itself is searched last.
    function automatic logic [AW-1:0] rr_next(input logic [N_WAYS-1:0] req,
                                              input logic [AW-1:0] cur);
        logic [AW-1:0] sel;
        logic          found;
        int            idx;
        sel   = cur;
        found = 1'b0;
        for (int k = 1; k <= N_WAYS; k++) begin
            idx = (int'(cur) + k) % N_WAYS;
            if (!found && req[idx]) begin
                sel   = AW'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    tlc_phase_timer #(.WIDTH(CW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_comb begin
        way_oh         = '0;
        way_oh[way_q]  = 1'b1;
        g_inc          = {1'b0, g_q} + 1'b1;
        pending        = |(req_q & ~way_oh);
`ifdef TLC_PED_EN
        pending        = pending | ped_q;
`endif
    end

    always_comb begin
        phase_d     = phase_q;
        way_d       = way_q;
        g_d         = (g_q == C_MAX) ? g_q : g_q + 1'b1;
        req_d       = req_q | bus.car_sense;
        tmr_load    = 1'b0;
        tmr_val     = '0;
        enter_green = 1'b0;
`ifdef TLC_PED_EN
        ped_d       = ped_q | bus.ped_req;
`endif
        case (phase_q)
            PH_GREEN: begin
                if (pending && ((!bus.car_sense[way_q] && g_inc >= C_MIN_X) ||
                                g_inc >= C_MAX_X)) begin
                    phase_d  = PH_YELLOW;
                    tmr_load = 1'b1;
                    tmr_val  = C_YEL;
                end
            end
            PH_YELLOW: begin
                if (tmr_done) begin
                    phase_d  = PH_ALL_RED;
                    tmr_load = 1'b1;
                    tmr_val  = C_AR;
                end
            end
            PH_ALL_RED: begin
                if (tmr_done) begin
`ifdef TLC_PED_EN
                    if (ped_q) begin
                        phase_d  = PH_WALK;
                        tmr_load = 1'b1;
                        tmr_val  = C_WALK;
                        ped_d    = 1'b0;
                    end else begin
                        enter_green = 1'b1;
                    end
`else
                    enter_green = 1'b1;
`endif
                end
            end
`ifdef TLC_PED_EN
            PH_WALK: begin
                if (tmr_done) enter_green = 1'b1;
            end
`endif
            default: phase_d = PH_GREEN;
        endcase

        // Entry clear wins over a sensor still high on the same edge.
        if (enter_green) begin
            way_d        = rr_next(req_q, way_q);
            phase_d      = PH_GREEN;
            g_d          = '0;
            req_d[way_d] = 1'b0;
        end
    end

    always_comb begin
        green_d  = '0;
        yellow_d = '0;
        red_d    = '0;
        lamp     = LAMP_RED;
        for (int i = 0; i < N_WAYS; i++) begin
            lamp = LAMP_RED;
            if (way_d == AW'(i)) begin
                if (phase_d == PH_GREEN)       lamp = LAMP_GREEN;
                else if (phase_d == PH_YELLOW) lamp = LAMP_YELLOW;
            end
            green_d[i]  = lamp[2];
            yellow_d[i] = lamp[1];
            red_d[i]    = lamp[0];
        end
`ifdef TLC_PED_EN
        walk_d = (phase_d == PH_WALK);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q  <= PH_GREEN;
            way_q    <= '0;
            g_q      <= '0;
            req_q    <= '0;
            green_q  <= C_LAMP0;
            yellow_q <= '0;
            red_q    <= ~C_LAMP0;
`ifdef TLC_PED_EN
            ped_q    <= 1'b0;
            walk_q   <= 1'b0;
`endif
        end else begin
            phase_q  <= phase_d;
            way_q    <= way_d;
            g_q      <= g_d;
            req_q    <= req_d;
            green_q  <= green_d;
            yellow_q <= yellow_d;
            red_q    <= red_d;
`ifdef TLC_PED_EN
            ped_q    <= ped_d;
            walk_q   <= walk_d;
`endif
        end
    end

    assign bus.green      = green_q;
    assign bus.yellow     = yellow_q;
    assign bus.red        = red_q;
    assign bus.active_way = way_q;
    assign bus.phase      = phase_q;
`ifdef TLC_PED_EN
    assign bus.walk       = walk_q;
`endif
endmodule
`default_nettype wire

// File: tb/tb_traffic_light_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_traffic_light_ctrl
// Brief  : Directed bench for traffic_light_ctrl with a cycle-level model.
//          Pedestrian scenario is included when TLC_PED_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
module tb_traffic_light_ctrl;
    localparam int N    = 3;
    localparam int MING = 4;
    localparam int MAXG = 10;
    localparam int YEL  = 2;
    localparam int AR   = 1;
    localparam int WLK  = 5;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] cs_drv = '0;
    int           n_checks = 0;
    int           n_errors = 0;

    always #5 clk = ~clk;

    tlc_if #(.N_WAYS(N)) bus ();
    assign bus.car_sense = cs_drv;
`ifdef TLC_PED_EN
    logic ped_drv = 1'b0;
    assign bus.ped_req = ped_drv;
`endif

    traffic_light_ctrl #(
        .N_WAYS(N), .MIN_GREEN(MING), .MAX_GREEN(MAXG),
        .YELLOW_CYCLES(YEL), .ALLRED_CYCLES(AR), .WALK_CYCLES(WLK)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Model: phase number, owning way, cycles elapsed in the current phase.
    int           m_phase, m_way, m_age;
    logic [N-1:0] m_req;
    bit           m_ped;

    function automatic int rr_pick(input logic [N-1:0] req, input int cur);
        for (int k = 1; k <= N; k++)
            if (req[(cur + k) % N]) return (cur + k) % N;
        return cur;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0; m_way <= 0; m_age <= 0; m_req <= '0; m_ped <= 1'b0;
        end else begin : step
            logic [N-1:0] nreq;
            bit           nped, pend, to_green;
            int           nphase, nway, nage;
            nreq     = m_req | cs_drv;
            nphase   = m_phase;
            nway     = m_way;
            nage     = m_age + 1;
            to_green = 1'b0;
            nped     = 1'b0;
            pend     = (m_req & ~(N'(1) << m_way)) != '0;
`ifdef TLC_PED_EN
            nped = m_ped | ped_drv;
            pend = pend | m_ped;
`endif
            case (m_phase)
                0: if (pend && ((!cs_drv[m_way] && m_age + 1 >= MING) || m_age + 1 >= MAXG)) begin
                    nphase = 1; nage = 0;
                end
                1: if (m_age + 1 == YEL) begin nphase = 2; nage = 0; end
                2: if (m_age + 1 == AR) begin
                    if (m_ped) begin nphase = 3; nage = 0; nped = 1'b0; end
                    else to_green = 1'b1;
                end
                default: if (m_age + 1 == WLK) to_green = 1'b1;
            endcase
            if (to_green) begin
                nway = rr_pick(m_req, m_way);
                nphase = 0; nage = 0;
                nreq[nway] = 1'b0;
            end
            m_phase <= nphase; m_way <= nway; m_age <= nage; m_req <= nreq; m_ped <= nped;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Every-cycle comparison of all lamps and status against the model.
    initial forever begin : cmp
        logic [N-1:0] eg, ey, er;
        logic [31:0]  got, exp;
        @(negedge clk);
        #2;
        eg = (m_phase == 0) ? (N'(1) << m_way) : '0;
        ey = (m_phase == 1) ? (N'(1) << m_way) : '0;
        er = ~(eg | ey);
        exp = {16'd0, 2'(m_way), 2'(m_phase), eg, ey, er};
        got = {16'd0, 2'(bus.active_way), bus.phase, bus.green, bus.yellow, bus.red};
        check("cycle_model", got, exp);
`ifdef TLC_PED_EN
        check("cycle_walk", {31'd0, bus.walk}, {31'd0, m_phase == 3});
`endif
    end

    task automatic cyc(input logic [N-1:0] cs);
        @(negedge clk);
        cs_drv = cs;
        #3;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        cs_drv = '0;
        @(negedge clk);
        rst_n = 1'b1;
        #3;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #3;
        check("rst_green", 32'(bus.green), 32'h1);
        check("rst_red", 32'(bus.red), 32'h6);
        check("rst_yellow", 32'(bus.yellow), 32'h0);
        check("rst_phase", 32'(bus.phase), 32'h0);
        repeat (50) cyc(3'b000);
        check("idle_green", 32'(bus.green), 32'h1);
        check("idle_phase", 32'(bus.phase), 32'h0);

        // Single request on way 2 one cycle after reset release
        do_reset();
        cyc(3'b100); cyc(3'b000); cyc(3'b000);
        check("t2_green_c3", 32'(bus.green), 32'h1);
        cyc(3'b000);
        check("t2_yellow_c4", 32'(bus.yellow), 32'h1);
        check("t2_phase_c4", 32'(bus.phase), 32'h1);
        cyc(3'b000);
        check("t2_yellow_c5", 32'(bus.yellow), 32'h1);
        cyc(3'b000);
        check("t2_allred", 32'(bus.red), 32'h7);
        check("t2_phase_ar", 32'(bus.phase), 32'h2);
        cyc(3'b000);
        check("t2_green_w2", 32'(bus.green), 32'h4);
        check("t2_way2", 32'(bus.active_way), 32'h2);

        // Way 0 held busy: served until max green
        do_reset();
        cyc(3'b011);
        repeat (7) cyc(3'b001);
        cyc(3'b001);
        check("t3_green_c9", 32'(bus.green), 32'h1);
        cyc(3'b001);
        check("t3_yellow_c10", 32'(bus.yellow), 32'h1);
        cyc(3'b001); cyc(3'b001); cyc(3'b001);
        check("t3_way1", 32'(bus.active_way), 32'h1);
        check("t3_green_w1", 32'(bus.green), 32'h2);
        repeat (6) cyc(3'b001);
        cyc(3'b000);
        check("t3_back_w0", 32'(bus.green), 32'h1);

        // Simultaneous requests on ways 1 and 2
        do_reset();
        cyc(3'b110);
        repeat (5) cyc(3'b000);
        cyc(3'b000);
        check("t4_way1", 32'(bus.active_way), 32'h1);
        repeat (7) cyc(3'b000);
        check("t4_green_w2", 32'(bus.green), 32'h4);
        repeat (6) cyc(3'b000);
        check("t4_stay_w2", 32'(bus.active_way), 32'h2);

        // Reset asserted during yellow
        do_reset();
        cyc(3'b100); cyc(3'b000); cyc(3'b010); cyc(3'b000);
        check("t5_in_yellow", 32'(bus.phase), 32'h1);
        @(negedge clk);
        rst_n = 1'b0;
        #3;
        check("t5_rst_green", 32'(bus.green), 32'h1);
        check("t5_rst_yellow", 32'(bus.yellow), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) cyc(3'b000);
        check("t5_req_lost", 32'(bus.green), 32'h1);
        check("t5_req_lost_ph", 32'(bus.phase), 32'h0);

`ifdef TLC_PED_EN
        do_reset();
        @(negedge clk);
        ped_drv = 1'b1;
        @(negedge clk);
        ped_drv = 1'b0;
        repeat (5) cyc(3'b000);
        check("t6_walk_on", 32'(bus.walk), 32'h1);
        check("t6_all_red", 32'(bus.red), 32'h7);
        check("t6_phase_walk", 32'(bus.phase), 32'h3);
        repeat (4) cyc(3'b000);
        check("t6_walk_last", 32'(bus.walk), 32'h1);
        cyc(3'b000);
        check("t6_walk_off", 32'(bus.walk), 32'h0);
        check("t6_green_w0", 32'(bus.green), 32'h1);
`endif

        repeat (2) @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/traffic_light_ctrl.md
# traffic_light_ctrl

Parametrised N-way traffic-light controller with internal phase timers, latched per-approach vehicle requests, round-robin arbitration and min/max green enforcement. It is the next-generation intersection controller: a single self-timed block replacing the two-road controller with external short/long timer inputs. It drives one green/yellow/red lamp triple per approach.

## Interface
- N_WAYS, 3: number of approaches; legal 2..8
- MIN_GREEN, 4: minimum green duration in cycles; ≥1
- MAX_GREEN, 10: maximum green while competing requests exist; ≥MIN_GREEN
- YELLOW_CYCLES, 2: yellow duration in cycles; ≥1
- ALLRED_CYCLES, 1: all-red clearance in cycles; ≥1
- WALK_CYCLES, 5: pedestrian walk duration in cycles; ≥1, used only with PED_EN

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- car_sense  in  N_WAYS  level vehicle sensor per approach
- ped_req  in  1  pedestrian button, 1-cycle pulse or level (PED_EN only)
- green  out  N_WAYS  green lamp per approach
- yellow  out  N_WAYS  yellow lamp per approach
- red  out  N_WAYS  red lamp per approach
- active_way  out  $clog2(N_WAYS)  approach currently owning the phase
- phase  out  2  0 GREEN, 1 YELLOW, 2 ALL_RED, 3 WALK
- walk  out  1  pedestrian walk lamp (PED_EN only)

## Operation
- States: GREEN, YELLOW, ALL_RED, WALK (PED_EN only). All outputs registered.
- Exactly one of green[i]/yellow[i]/red[i] high per approach at all times; only active_way may be non-red, and only in GREEN/YELLOW.
- req_q[i] latches car_sense[i]; cleared on the cycle approach i enters GREEN. A sensor high on the clear cycle is re-latched the next cycle only if still high.
- pending = |(req_q & ~onehot(active_way)).
- GREEN: counter g counts cycles in green from 0, saturating at MAX_GREEN. Exit to YELLOW when pending and either (car_sense[active_way]==0 and g+1≥MIN_GREEN) or g+1≥MAX_GREEN. No pending: remain green indefinitely.
- YELLOW: exactly YELLOW_CYCLES cycles, then ALL_RED.
- ALL_RED: exactly ALLRED_CYCLES cycles; then next active_way = first i with req_q[i] searching active_way+1, +2, … modulo N_WAYS; enter GREEN.
- Counter width: $clog2(max of timing parameters + 1); no wrap, all counters saturate or reload.

## Timing
- Reset (async assert, sync-release use): phase=GREEN, active_way=0, green=1 at bit 0 only, red=all others, yellow=0, walk=0, req_q=0, g=0.
- Reset mid-phase: immediate return to the reset values above; latched requests lost.
- Sensor to req_q latency: 1 cycle. Exit decisions use registered req_q, so a request arriving on cycle t can first cause exit at edge t+2.
- Phase lengths exact: green ≥MIN_GREEN cycles, yellow YELLOW_CYCLES, all-red ALLRED_CYCLES.
- Simultaneous requests: resolved purely by round-robin order from active_way+1.

## Configuration
- TLC_PED_EN defined: ped_req latched into ped_q; ped_q counts as pending in GREEN. At ALL_RED end with ped_q set, enter WALK (all lamps red, walk=1) for WALK_CYCLES, clear ped_q on WALK entry, then perform the round-robin GREEN selection; if no req_q set, return to active_way.
- Undefined: no ped_req/walk ports, no WALK state; phase never equals 3.

## Structure
- Package tlc_pkg: phase enum (GREEN/YELLOW/ALL_RED/WALK), lamp encoding constants, counter-width function.
- Sub-module tlc_phase_timer: loadable down-counter with done flag, instantiated once and reloaded per phase; green-age counter g lives in the top.
- Round-robin next-way search is a combinational function in the top.

## Test plan
- Defaults; reset, car_sense=0 for 50 cycles -> green=3'b001, red=3'b110, phase=0 throughout.
- car_sense=3'b100 pulsed 1 cycle at cycle 1 -> way 0 green 4 cycles, yellow=3'b001 2 cycles, all red 1 cycle, then green=3'b100, active_way=2.
- car_sense[0] held high plus car_sense[1] pulsed -> way 0 green exactly 10 cycles before yellow.
- car_sense=3'b110 pulsed together -> way 1 served next, then way 2 after its min green; way 0 not re-served.
- rst_n low during YELLOW -> green=3'b001 same cycle as assertion, req_q cleared.
- TLC_PED_EN defined, ped_req pulse while way 0 green -> after yellow and all-red, walk=1 and red=3'b111 for 5 cycles, then way 0 green again.
